// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: boot defaults, FSM state encoding and the
// alignment check applied whenever the FSM is about to issue a new fetch.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  // Every path into REQ lands here: a misaligned target parks the stage in FAULT.
  function automatic fetch_state_t req_entry(input logic [31:0] target);
    return (target[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack
// and presents a one-entry instruction register to decode via valid/ready.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_BOOT  | first cycle after reset, no request yet
//   ST_REQ   | read in flight at pc
//   ST_HOLD  | IR holds a correct-path word, waiting for decode
//   ST_DRAIN | redirected mid-read; finishing the old read at req_addr
//   ST_FAULT | misaligned target, fetch halted until the next redirect
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir_instr,
  output logic [31:0] ir_pc,
  output logic        fetch_fault
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  req_addr, req_addr_n;
  logic [31:0]  ir_instr_q, ir_instr_n;
  logic [31:0]  ir_pc_q, ir_pc_n;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      ir_instr_q <= NOP_INSTR;
      ir_pc_q    <= 32'h0000_0000;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      ir_instr_q <= ir_instr_n;
      ir_pc_q    <= ir_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    ir_instr_n = ir_instr_q;
    ir_pc_n    = ir_pc_q;

    case (state)
      ST_BOOT: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = req_entry(redirect_pc);
        end else begin
          state_n = req_entry(pc);
        end
      end

      ST_REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (mem_ack) begin
            state_n = req_entry(redirect_pc);
          end else begin
            // The read already on the bus must finish at its original address.
            req_addr_n = pc;
            state_n    = ST_DRAIN;
          end
        end else if (mem_ack) begin
          ir_instr_n = mem_rdata;
          ir_pc_n    = pc;
          pc_n       = pc + 32'd4;
          state_n    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_n       = redirect_pc;
          ir_instr_n = NOP_INSTR;
          state_n    = req_entry(redirect_pc);
        end else if (ir_ready) begin
          state_n = req_entry(pc);
        end
      end

      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
        end
        // The drained word is dropped; a redirect in the same cycle still retargets.
        if (mem_ack) begin
          state_n = req_entry(pc_n);
        end
      end

      ST_FAULT: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = req_entry(redirect_pc);
        end
      end

      default: state_n = ST_BOOT;
    endcase
  end

  assign mem_req     = (state == ST_REQ) || (state == ST_DRAIN);
  assign mem_addr    = (state == ST_DRAIN) ? req_addr : pc;
  assign ir_valid    = (state == ST_HOLD);
  assign fetch_fault = (state == ST_FAULT);
  assign ir_instr    = ir_instr_q;
  assign ir_pc       = ir_pc_q;

endmodule
